service_protocol_decoder_p: RTL and testbench

Parametrised successor to the service protocol decoder. Consumes the word stream from the SPI receiver push output and parses packets of the form [addr|rsvd], [size|cmd], size data words, checksum. Adds the following over the previous generation:
- generic word width;
- runtime own-address plus a broadcast address;
- checksum verification;
- maximum-size check;
- inter-word timeout;
- silent skipping of packets addressed to other modules.

---
 rtl/service_protocol_decoder_p.sv | 166 ++++++++++++++++
 tb/tb_service_protocol_decoder_p.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/service_protocol_decoder_p.sv
// Packet parser for the SPI receiver word stream: [addr|rsvd] [size|cmd] data... checksum.
// Adds address filtering, checksum/size/timeout checking and silent skipping of foreign packets.
module service_protocol_decoder_p #(
  parameter int                  DATA_W     = 16,
  parameter int                  MAX_SIZE   = 64,
  parameter logic [DATA_W/2-1:0] BCAST_ADDR = {(DATA_W/2){1'b1}},
  parameter int                  TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W/2-1:0]   own_addr,
  input  logic                  in_request,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_request,
  output logic [DATA_W-1:0]     out_data,
  output logic                  packet_start,
  output logic [DATA_W/2-1:0]   module_addr,
  output logic [DATA_W/2-1:0]   cmd_code,
  output logic [DATA_W/2-1:0]   size,
  output logic                  packet_end,
  output logic                  packet_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for word0 (address)
  // HDR   | waiting for word1 (size/cmd)
  // DATA  | forwarding data words of an accepted packet
  // CSUM  | waiting for the checksum word of an accepted packet
  // SKIP  | discarding data + checksum of a packet for another module

  localparam int HW = DATA_W / 2;
  localparam int CW = HW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_SIZE);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_SIZE = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    SKIP = 3'd4
  } state_t;

  state_t            state;
  logic              matched;
  logic [HW-1:0]     pend_addr;
  logic [DATA_W-1:0] sum;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     timer;

  logic [HW-1:0]     in_hi;
  logic [HW-1:0]     in_lo;
  logic              csum_bad;

  assign in_hi    = in_data[DATA_W-1:HW];
  assign in_lo    = in_data[HW-1:0];
  assign csum_bad = (in_data != sum);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      matched      <= 1'b0;
      pend_addr    <= '0;
      sum          <= '0;
      cnt          <= '0;
      timer        <= '0;
      out_request  <= 1'b0;
      out_data     <= '0;
      packet_start <= 1'b0;
      module_addr  <= '0;
      cmd_code     <= '0;
      size         <= '0;
      packet_end   <= 1'b0;
      packet_err   <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      out_request  <= 1'b0;
      packet_start <= 1'b0;
      packet_end   <= 1'b0;

      if (state != IDLE && !in_request) begin
        // timer holds the idle cycles still allowed; a word in the terminal cycle wins
        if (timer == '0) begin
          state <= IDLE;
          cnt   <= '0;
          if (matched && (state == DATA || state == CSUM)) begin
            packet_end <= 1'b1;
            packet_err <= 1'b1;
            err_code   <= ERR_TOUT;
          end
        end else begin
          timer <= timer - 1'b1;
        end
      end else if (in_request) begin
        timer <= TIMER_LOAD;
        unique case (state)
          IDLE: begin
            pend_addr <= in_hi;
            sum       <= in_data;
            matched   <= (in_hi == own_addr) || (in_hi == BCAST_ADDR);
            state     <= HDR;
          end
          HDR: begin
            sum <= sum + in_data;
            if ({1'b0, in_hi} > MAX_CNT) begin
              state <= IDLE;
              timer <= '0;
              if (matched) begin
                packet_end <= 1'b1;
                packet_err <= 1'b1;
                err_code   <= ERR_SIZE;
              end
            end else if (matched) begin
              module_addr  <= pend_addr;
              cmd_code     <= in_lo;
              size         <= in_hi;
              packet_start <= 1'b1;
              cnt          <= {1'b0, in_hi};
              state        <= (in_hi == '0) ? CSUM : DATA;
            end else begin
              // foreign packet: skip its data words plus the checksum word
              cnt   <= {1'b0, in_hi} + 1'b1;
              state <= SKIP;
            end
          end
          DATA: begin
            out_request <= 1'b1;
            out_data    <= in_data;
            sum         <= sum + in_data;
            cnt         <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= CSUM;
          end
          CSUM: begin
            packet_end <= 1'b1;
            packet_err <= csum_bad;
            err_code   <= csum_bad ? ERR_CSUM : ERR_NONE;
            state      <= IDLE;
            timer      <= '0;
          end
          SKIP: begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state <= IDLE;
              timer <= '0;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_service_protocol_decoder_p.sv
// Self-checking bench for service_protocol_decoder_p: packet vector table plus hand-written
// timeout, boundary and reset sequences, checked against an event scoreboard.
module tb_service_protocol_decoder_p;

  localparam int DW = 16;
  localparam int HW = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [HW-1:0] own_addr = 8'hAB;
  logic          in_request = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_request;
  logic [DW-1:0] out_data;
  logic          packet_start;
  logic [HW-1:0] module_addr;
  logic [HW-1:0] cmd_code;
  logic [HW-1:0] size;
  logic          packet_end;
  logic          packet_err;
  logic [1:0]    err_code;
  logic          busy;

  service_protocol_decoder_p #(
    .DATA_W(DW), .MAX_SIZE(4), .BCAST_ADDR(8'hFF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .own_addr(own_addr), .in_request(in_request), .in_data(in_data),
    .out_request(out_request), .out_data(out_data), .packet_start(packet_start),
    .module_addr(module_addr), .cmd_code(cmd_code), .size(size), .packet_end(packet_end),
    .packet_err(packet_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 data word, 1 packet_start, 2 packet_end
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    logic [HW-1:0] a, c, s;
    logic          err;
    logic [1:0]    code;
    int            at;
  } ev_t;

  typedef struct {
    logic [HW-1:0] own;
    int            first, n, gap;
    bit            es;
    logic [HW-1:0] a, c, s;
    int            nd;
    bit            ee;
    logic          eerr;
    logic [1:0]    ec;
  } vec_t;

  ev_t           sb[$];
  vec_t          vecs[$];
  logic [DW-1:0] wl[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic push_ev(input int k, input logic [DW-1:0] d, input logic [HW-1:0] a, c, s,
                         input logic err, input logic [1:0] code, input int at);
    ev_t e;
    e.kind = k; e.data = d; e.a = a; e.c = c; e.s = s; e.err = err; e.code = code; e.at = at;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", k, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k) begin
      n_bad++;
      $display("FAIL event_order: got kind %0d, required kind %0d", k, e.kind);
    end else if (k == 0) begin
      if (out_data !== e.data) begin
        n_bad++;
        $display("FAIL out_data: got %h, required %h", out_data, e.data);
      end
    end else if (k == 1) begin
      if ({module_addr, cmd_code, size} !== {e.a, e.c, e.s}) begin
        n_bad++;
        $display("FAIL header: got addr %h cmd %h size %h, required %h %h %h",
                 module_addr, cmd_code, size, e.a, e.c, e.s);
      end
    end else begin
      if ({packet_err, err_code} !== {e.err, e.code} || (e.at >= 0 && cyc != e.at)) begin
        n_bad++;
        $display("FAIL packet_end: got err %b code %0d cycle %0d, required err %b code %0d cycle %0d",
                 packet_err, err_code, cyc, e.err, e.code, e.at);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (packet_start === 1'b1 && packet_end === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL start_end_overlap: got both high at cycle %0d, required never together", cyc);
      end
      if (packet_start === 1'b1) check_ev(1);
      if (out_request === 1'b1)  check_ev(0);
      if (packet_end === 1'b1)   check_ev(2);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    @(negedge clk);
    in_request = 1'b1;
    in_data    = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_request = 1'b0;
    end
  endtask

  task automatic check_done(input string tag);
    int waited = 0;
    while (busy !== 1'b0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_%s: got %0d pending events busy %b, required 0 pending busy 0",
               tag, sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic add_vec(input logic [HW-1:0] own, input int gap, input bit es,
                         input logic [HW-1:0] a, c, s, input int nd, input bit ee,
                         input logic eerr, input logic [1:0] ec, input int n,
                         input logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6);
    vec_t v;
    logic [DW-1:0] w[7];
    w = '{w0, w1, w2, w3, w4, w5, w6};
    v.own = own; v.first = wl.size(); v.n = n; v.gap = gap; v.es = es;
    v.a = a; v.c = c; v.s = s; v.nd = nd; v.ee = ee; v.eerr = eerr; v.ec = ec;
    for (int i = 0; i < n; i++) wl.push_back(w[i]);
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [DW-1:0] w;
    own_addr = v.own;
    for (int i = 0; i < v.n; i++) begin
      w = wl[v.first + i];
      if (i == 1 && v.es) push_ev(1, '0, v.a, v.c, v.s, 1'b0, 2'd0, -1);
      if (i >= 2 && i < 2 + v.nd) push_ev(0, w, '0, '0, '0, 1'b0, 2'd0, -1);
      if (i == v.n - 1 && v.ee) push_ev(2, '0, '0, '0, '0, v.eerr, v.ec, -1);
      send_word(w);
      if (i < v.n - 1) idle(v.gap);
    end
    idle(6);
    check_done($sformatf("vec%0d", idx));
  endtask

  int t0;

  initial begin
    fork
      monitor();
    join_none

    //        own    gap es  a      c      s      nd ee err code n
    add_vec(8'hAB, 2, 1, 8'hAB, 8'hA2, 8'h02, 2, 1, 0, 2'd0, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0, 16'h0);
    add_vec(8'hAB, 1, 1, 8'hAB, 8'hA2, 8'h02, 2, 1, 1, 2'd1, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4F, 16'h0, 16'h0);
    add_vec(8'hAC, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd0, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0, 16'h0);
    add_vec(8'hAC, 1, 1, 8'hFF, 8'hA2, 8'h02, 2, 1, 0, 2'd0, 5,
            16'hFF00, 16'h02A2, 16'hEFAB, 16'h0001, 16'hF14E, 16'h0, 16'h0);
    add_vec(8'hAB, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'd2, 2,
            16'hAB00, 16'h05A2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    add_vec(8'hAB, 3, 1, 8'hAB, 8'hA2, 8'h02, 2, 1, 0, 2'd0, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0, 16'h0);
    add_vec(8'hAB, 1, 1, 8'hAB, 8'hA5, 8'h00, 0, 1, 0, 2'd0, 3,
            16'hAB00, 16'h00A5, 16'hABA5, 16'h0, 16'h0, 16'h0, 16'h0);
    add_vec(8'hAB, 0, 1, 8'hAB, 8'hA2, 8'h02, 2, 1, 0, 2'd0, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0, 16'h0);
    add_vec(8'hAB, 0, 1, 8'hAB, 8'hA1, 8'h04, 4, 1, 0, 2'd0, 7,
            16'hAB00, 16'h04A1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hAFAB);
    add_vec(8'hAC, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd0, 3,
            16'hAB00, 16'h00A5, 16'hABA5, 16'h0, 16'h0, 16'h0, 16'h0);
    add_vec(8'hAC, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd0, 2,
            16'hAB00, 16'h05A2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    add_vec(8'hAB, 0, 1, 8'hAB, 8'hA2, 8'h02, 2, 1, 1, 2'd1, 5,
            16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4F, 16'h0, 16'h0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_request, out_data, packet_start, module_addr, cmd_code, size,
         packet_end, packet_err, err_code, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got req %b data %h start %b addr %h cmd %h size %h end %b err %b code %0d busy %b, required all 0",
               out_request, out_data, packet_start, module_addr, cmd_code, size,
               packet_end, packet_err, err_code, busy);
    end

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // timeout: last word captured at cycle t0, error pulse TO cycles later
    own_addr = 8'hAB;
    send_word(16'hAB00);
    push_ev(1, '0, 8'hAB, 8'hA2, 8'h02, 1'b0, 2'd0, -1);
    send_word(16'h02A2);
    push_ev(0, 16'hEFAB, '0, '0, '0, 1'b0, 2'd0, -1);
    send_word(16'hEFAB);
    @(negedge clk);
    in_request = 1'b0;
    t0 = cyc;
    push_ev(2, '0, '0, '0, '0, 1'b1, 2'd3, t0 + TO);
    idle(40);
    check_done("timeout");

    // word arriving in the terminal cycle beats the timeout
    send_word(16'hAB00);
    push_ev(1, '0, 8'hAB, 8'hA2, 8'h02, 1'b0, 2'd0, -1);
    send_word(16'h02A2);
    push_ev(0, 16'hEFAB, '0, '0, '0, 1'b0, 2'd0, -1);
    send_word(16'hEFAB);
    @(negedge clk);
    in_request = 1'b0;
    t0 = cyc;
    repeat (TO - 1) @(negedge clk);
    push_ev(0, 16'h0001, '0, '0, '0, 1'b0, 2'd0, -1);
    in_request = 1'b1;
    in_data    = 16'h0001;
    push_ev(2, '0, '0, '0, '0, 1'b0, 2'd0, -1);
    send_word(16'h9D4E);
    idle(6);
    check_done("timeout_boundary");

    // reset mid-packet: EFAB is already on its way out, no packet_end follows
    send_word(16'hAB00);
    push_ev(1, '0, 8'hAB, 8'hA2, 8'h02, 1'b0, 2'd0, -1);
    send_word(16'h02A2);
    push_ev(0, 16'hEFAB, '0, '0, '0, 1'b0, 2'd0, -1);
    send_word(16'hEFAB);
    @(negedge clk);
    in_request = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_request, out_data, packet_start, module_addr, cmd_code, size,
         packet_end, packet_err, err_code, busy} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got req %b data %h start %b addr %h cmd %h size %h end %b err %b code %0d busy %b, required all 0",
               out_request, out_data, packet_start, module_addr, cmd_code, size,
               packet_end, packet_err, err_code, busy);
    end
    idle(6);
    check_done("mid_reset");

    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
